// File: rtl/mem_stage.sv
// Memory-access stage: registers non-memory bundles straight through to write-back
// and runs a req/ack bus transaction (with optional timeout) for loads and stores.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memi_valid,
    input  logic [15:0] memi_instr,
    input  logic [15:0] memi_pc,
    input  logic [15:0] memi_result,
    input  logic [3:0]  memi_wreg_addr,
    input  logic [15:0] memi_write_to_mem_data,
    input  logic [1:0]  memi_rwe,
    input  logic        memi_branch,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic        memo_valid,
    output logic [15:0] memo_instr,
    output logic [15:0] memo_pc,
    output logic [3:0]  memo_wreg_addr,
    output logic [15:0] memo_wdata,
    output logic        memo_branch,
    output logic        memo_bus_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] COUNT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  count;
    logic        is_mem;
    logic        timed_out;

    // Bundle fields held while the bus transaction is outstanding
    logic [15:0] hold_instr;
    logic [15:0] hold_pc;
    logic [3:0]  hold_wreg_addr;
    logic        hold_branch;
    logic        hold_load;

    assign mem_stall = (state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        is_mem     = memi_valid && ((memi_rwe == 2'b10) || (memi_rwe == 2'b01));
        timed_out  = (TIMEOUT != 0) && !bus_ack && (count == COUNT_LAST);
        case (state)
            IDLE: begin
                if (is_mem) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack || timed_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= 8'd0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 16'd0;
            bus_wdata      <= 16'd0;
            memo_valid     <= 1'b0;
            memo_instr     <= 16'd0;
            memo_pc        <= 16'd0;
            memo_wreg_addr <= 4'd0;
            memo_wdata     <= 16'd0;
            memo_branch    <= 1'b0;
            memo_bus_err   <= 1'b0;
            hold_instr     <= 16'd0;
            hold_pc        <= 16'd0;
            hold_wreg_addr <= 4'd0;
            hold_branch    <= 1'b0;
            hold_load      <= 1'b0;
        end else begin
            memo_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        hold_instr     <= memi_instr;
                        hold_pc        <= memi_pc;
                        hold_wreg_addr <= memi_wreg_addr;
                        hold_branch    <= memi_branch;
                        hold_load      <= memi_rwe[1];
                        bus_addr       <= memi_result;
                        bus_wdata      <= memi_write_to_mem_data;
                        bus_we         <= memi_rwe[0];
                        bus_req        <= 1'b1;
                        count          <= 8'd0;
                    end else if (memi_valid) begin
                        memo_valid     <= 1'b1;
                        memo_instr     <= memi_instr;
                        memo_pc        <= memi_pc;
                        memo_wreg_addr <= memi_wreg_addr;
                        memo_branch    <= memi_branch;
                        memo_wdata     <= memi_result;
                        memo_bus_err   <= 1'b0;
                    end
                end
                BUSY: begin
                    count <= count + 8'd1;
                    if (bus_ack || timed_out) begin
                        bus_req        <= 1'b0;
                        memo_valid     <= 1'b1;
                        memo_instr     <= hold_instr;
                        memo_pc        <= hold_pc;
                        memo_wreg_addr <= hold_wreg_addr;
                        memo_branch    <= hold_branch;
                    end
                    // Ack takes priority over a timeout landing on the same edge
                    if (bus_ack) begin
                        memo_bus_err <= 1'b0;
                        memo_wdata   <= hold_load ? bus_rdata : bus_addr;
                    end else if (timed_out) begin
                        memo_bus_err <= 1'b1;
                        memo_wdata   <= 16'h00fe;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage built with TIMEOUT = 4.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        memi_valid;
    logic [15:0] memi_instr;
    logic [15:0] memi_pc;
    logic [15:0] memi_result;
    logic [3:0]  memi_wreg_addr;
    logic [15:0] memi_write_to_mem_data;
    logic [1:0]  memi_rwe;
    logic        memi_branch;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        memo_valid;
    logic [15:0] memo_instr;
    logic [15:0] memo_pc;
    logic [3:0]  memo_wreg_addr;
    logic [15:0] memo_wdata;
    logic        memo_branch;
    logic        memo_bus_err;

    int compared;
    int mismatched;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .memi_valid             (memi_valid),
        .memi_instr             (memi_instr),
        .memi_pc                (memi_pc),
        .memi_result            (memi_result),
        .memi_wreg_addr         (memi_wreg_addr),
        .memi_write_to_mem_data (memi_write_to_mem_data),
        .memi_rwe               (memi_rwe),
        .memi_branch            (memi_branch),
        .mem_stall              (mem_stall),
        .bus_req                (bus_req),
        .bus_we                 (bus_we),
        .bus_addr               (bus_addr),
        .bus_wdata              (bus_wdata),
        .bus_rdata              (bus_rdata),
        .bus_ack                (bus_ack),
        .memo_valid             (memo_valid),
        .memo_instr             (memo_instr),
        .memo_pc                (memo_pc),
        .memo_wreg_addr         (memo_wreg_addr),
        .memo_wdata             (memo_wdata),
        .memo_branch            (memo_branch),
        .memo_bus_err           (memo_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] rwe, input logic [15:0] result,
                                 input logic [15:0] wdata, input logic [3:0] wreg);
        memi_valid             = valid;
        memi_rwe               = rwe;
        memi_result            = result;
        memi_write_to_mem_data = wdata;
        memi_wreg_addr         = wreg;
    endtask

    // Advance one edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus_ack    = 1'b0;
        bus_rdata  = 16'd0;
        memi_instr = 16'ha001;
        memi_pc    = 16'h0010;
        memi_branch = 1'b0;
        applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 4'd0);
        tick();
        tick();
        checkOutput("rst_memo_valid", 16'(memo_valid), 16'd0);
        checkOutput("rst_bus_req", 16'(bus_req), 16'd0);
        checkOutput("rst_stall", 16'(mem_stall), 16'd0);
        checkOutput("rst_wdata", memo_wdata, 16'd0);
        checkOutput("rst_addr", bus_addr, 16'd0);

        // Reset while a load is outstanding
        rst = 1'b0;
        applyStimulus(1'b1, 2'b10, 16'h0040, 16'd0, 4'h2);
        tick();
        checkOutput("rb_req_e0", 16'(bus_req), 16'd1);
        checkOutput("rb_stall_e0", 16'(mem_stall), 16'd1);
        applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 4'd0);
        tick();
        checkOutput("rb_valid_e1", 16'(memo_valid), 16'd0);
        tick();
        checkOutput("rb_valid_e2", 16'(memo_valid), 16'd0);
        rst = 1'b1;
        tick();
        checkOutput("rb_req_after", 16'(bus_req), 16'd0);
        checkOutput("rb_stall_after", 16'(mem_stall), 16'd0);
        checkOutput("rb_valid_after", 16'(memo_valid), 16'd0);
        checkOutput("rb_addr_after", bus_addr, 16'd0);
        rst = 1'b0;
        tick();
        checkOutput("rb_valid_idle", 16'(memo_valid), 16'd0);

        // Non-memory bundles back to back
        memi_branch = 1'b1;
        applyStimulus(1'b1, 2'b00, 16'h1234, 16'hffff, 4'h3);
        tick();
        checkOutput("nm1_valid", 16'(memo_valid), 16'd1);
        checkOutput("nm1_wdata", memo_wdata, 16'h1234);
        checkOutput("nm1_wreg", 16'(memo_wreg_addr), 16'h3);
        checkOutput("nm1_branch", 16'(memo_branch), 16'd1);
        checkOutput("nm1_pc", memo_pc, 16'h0010);
        checkOutput("nm1_stall", 16'(mem_stall), 16'd0);
        memi_branch = 1'b0;
        memi_pc     = 16'h0011;
        applyStimulus(1'b1, 2'b11, 16'h5678, 16'h0000, 4'h7);
        tick();
        checkOutput("nm2_valid", 16'(memo_valid), 16'd1);
        checkOutput("nm2_wdata", memo_wdata, 16'h5678);
        checkOutput("nm2_wreg", 16'(memo_wreg_addr), 16'h7);
        checkOutput("nm2_stall", 16'(mem_stall), 16'd0);
        checkOutput("nm2_req", 16'(bus_req), 16'd0);
        applyStimulus(1'b0, 2'b00, 16'h9999, 16'd0, 4'hf);
        tick();
        checkOutput("nm_idle_valid", 16'(memo_valid), 16'd0);
        checkOutput("nm_idle_hold", memo_wdata, 16'h5678);

        // Load acked on the third BUSY edge
        memi_pc = 16'h0020;
        applyStimulus(1'b1, 2'b10, 16'h0040, 16'h1111, 4'h5);
        tick();
        applyStimulus(1'b0, 2'b00, 16'hdead, 16'd0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("ld_req_%0d", i), 16'(bus_req), 16'd1);
            checkOutput($sformatf("ld_stall_%0d", i), 16'(mem_stall), 16'd1);
            checkOutput($sformatf("ld_valid_%0d", i), 16'(memo_valid), 16'd0);
            if (i == 0) begin
                checkOutput("ld_addr", bus_addr, 16'h0040);
                checkOutput("ld_we", 16'(bus_we), 16'd0);
            end
            if (i == 2) begin
                bus_ack   = 1'b1;
                bus_rdata = 16'hbeef;
            end
            tick();
        end
        bus_ack = 1'b0;
        checkOutput("ld_req_done", 16'(bus_req), 16'd0);
        checkOutput("ld_valid", 16'(memo_valid), 16'd1);
        checkOutput("ld_wdata", memo_wdata, 16'hbeef);
        checkOutput("ld_err", 16'(memo_bus_err), 16'd0);
        checkOutput("ld_wreg", 16'(memo_wreg_addr), 16'h5);
        checkOutput("ld_pc", memo_pc, 16'h0020);
        checkOutput("ld_stall_done", 16'(mem_stall), 16'd0);
        tick();
        checkOutput("ld_pulse_end", 16'(memo_valid), 16'd0);

        // Stray ack while idle is ignored
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        checkOutput("idle_ack_valid", 16'(memo_valid), 16'd0);
        checkOutput("idle_ack_stall", 16'(mem_stall), 16'd0);

        // Store acked immediately
        applyStimulus(1'b1, 2'b01, 16'h0100, 16'h5a5a, 4'h9);
        tick();
        checkOutput("st_we", 16'(bus_we), 16'd1);
        checkOutput("st_wdata_bus", bus_wdata, 16'h5a5a);
        checkOutput("st_addr", bus_addr, 16'h0100);
        applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 4'h0);
        bus_ack   = 1'b1;
        bus_rdata = 16'h7777;
        tick();
        bus_ack = 1'b0;
        checkOutput("st_valid", 16'(memo_valid), 16'd1);
        checkOutput("st_wdata", memo_wdata, 16'h0100);
        checkOutput("st_err", 16'(memo_bus_err), 16'd0);
        checkOutput("st_req_done", 16'(bus_req), 16'd0);

        // Load with no ack times out after four BUSY cycles
        applyStimulus(1'b1, 2'b10, 16'h0200, 16'd0, 4'h4);
        tick();
        applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("to_req_%0d", i), 16'(bus_req), 16'd1);
            tick();
        end
        checkOutput("to_req_done", 16'(bus_req), 16'd0);
        checkOutput("to_valid", 16'(memo_valid), 16'd1);
        checkOutput("to_err", 16'(memo_bus_err), 16'd1);
        checkOutput("to_wdata", memo_wdata, 16'h00fe);
        checkOutput("to_wreg", 16'(memo_wreg_addr), 16'h4);
        tick();
        checkOutput("to_pulse_end", 16'(memo_valid), 16'd0);

        // Ack arriving on the timeout edge wins
        applyStimulus(1'b1, 2'b10, 16'h0300, 16'd0, 4'h6);
        tick();
        applyStimulus(1'b0, 2'b00, 16'd0, 16'd0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ta_req_%0d", i), 16'(bus_req), 16'd1);
            if (i == 3) begin
                bus_ack   = 1'b1;
                bus_rdata = 16'h1357;
            end
            tick();
        end
        bus_ack = 1'b0;
        checkOutput("ta_valid", 16'(memo_valid), 16'd1);
        checkOutput("ta_err", 16'(memo_bus_err), 16'd0);
        checkOutput("ta_wdata", memo_wdata, 16'h1357);
        checkOutput("ta_req_done", 16'(bus_req), 16'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
